// File: rtl/handover_scheduler_pkg.sv
// Shared types and defaults for the handover scheduler: FSM state encoding,
// default sizing constants and the modular index helper used by the arbiter.
package handover_pkg;

  localparam int N_AGENTS_DEF = 4;
  localparam int TIMEOUT_DEF  = 15;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // (base + off) mod n, valid for base < n and off < n
  function automatic int wrap_inc(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/handover_scheduler_if.sv
// Handshake bundle between the requesting agents / receiver and the scheduler.
// The scheduler uses the slave side; agents and the receiver use the master side.
interface handover_scheduler_if import handover_pkg::*; #(
  parameter int N_AGENTS = N_AGENTS_DEF
) ();

  localparam int IW = $clog2(N_AGENTS);

  logic [N_AGENTS-1:0] req;
  logic                ack;
  logic [N_AGENTS-1:0] grant;
  logic                send_en;
  logic                busy;
  logic                done;
  logic                timeout_err;
  logic [7:0]          handover_count;
  logic [IW-1:0]       last_owner;

  modport master (
    output req, ack,
    input  grant, send_en, busy, done, timeout_err, handover_count, last_owner
  );

  modport slave (
    input  req, ack,
    output grant, send_en, busy, done, timeout_err, handover_count, last_owner
  );

endinterface

// File: rtl/handover_scheduler_arb.sv
// Combinational round-robin arbiter: first asserted request at or above ptr,
// wrapping past the top agent. Produces both one-hot and binary winner.
module rr_arbiter import handover_pkg::*; #(
  parameter int N  = N_AGENTS_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] index
);

  logic          w_found;
  logic [IW-1:0] w_cand;

  always_comb begin
    gnt     = '0;
    index   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = IW'(wrap_inc(int'(ptr), k, N));
      if (!w_found && req[w_cand]) begin
        w_found     = 1'b1;
        gnt[w_cand] = 1'b1;
        index       = w_cand;
      end
    end
  end

endmodule

// File: rtl/handover_scheduler.sv
// Handover scheduler: grants the shared agent datapath to one requester at a
// time, strobes send_en once, then waits for ack or aborts after TIMEOUT cycles.
module handover_scheduler import handover_pkg::*; #(
  parameter int N_AGENTS = N_AGENTS_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  handover_scheduler_if.slave  hs
);

  localparam int IW = $clog2(N_AGENTS);

  state_t              r_state;
  logic [N_AGENTS-1:0] r_grant;
  logic                r_send_en;
  logic                r_busy;
  logic                r_done;
  logic                r_timeout_err;
  logic [7:0]          r_count;
  logic [7:0]          r_timer;
  logic [IW-1:0]       r_last_owner;
  logic [IW-1:0]       r_ptr;
  logic [IW-1:0]       r_winner;

  logic [N_AGENTS-1:0] w_gnt;
  logic [IW-1:0]       w_idx;
  logic [IW-1:0]       w_ptr_next;
  logic                w_timer_hit;

  rr_arbiter #(.N(N_AGENTS), .IW(IW)) u_arb (
    .req   (hs.req),
    .ptr   (r_ptr),
    .gnt   (w_gnt),
    .index (w_idx)
  );

  assign w_ptr_next  = (int'(r_winner) == N_AGENTS - 1) ? '0 : r_winner + IW'(1);
  // Timer counts completed WAIT_ACK cycles; the TIMEOUT-th one without ack aborts,
  // so WAIT_ACK never lasts more than TIMEOUT cycles.
  assign w_timer_hit = (r_timer + 8'd1) == 8'(TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_send_en     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_count       <= '0;
      r_timer       <= '0;
      r_last_owner  <= '0;
      r_ptr         <= '0;
      r_winner      <= '0;
    end else begin
      r_send_en     <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|hs.req) begin
            r_grant   <= w_gnt;
            r_winner  <= w_idx;
            r_send_en <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= SEND;
          end
        end
        SEND: begin
          r_timer <= '0;
          r_state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // ack takes priority over a simultaneous timeout
          if (hs.ack || w_timer_hit) begin
            r_state      <= RELEASE;
            r_grant      <= '0;
            r_last_owner <= r_winner;
            r_ptr        <= w_ptr_next;
            if (hs.ack) begin
              r_done  <= 1'b1;
              r_count <= r_count + 8'd1;
            end else begin
              r_timeout_err <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        RELEASE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign hs.grant          = r_grant;
  assign hs.send_en        = r_send_en;
  assign hs.busy           = r_busy;
  assign hs.done           = r_done;
  assign hs.timeout_err    = r_timeout_err;
  assign hs.handover_count = r_count;
  assign hs.last_owner     = r_last_owner;

endmodule

// File: tb/tb_handover_scheduler.sv
// Randomized bench for handover_scheduler: a transaction-level model predicts
// each handover (winner, outcome, count, latency) into queues; a monitor checks.
module tb_handover_scheduler;

  localparam int N  = 4;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  handover_scheduler_if #(.N_AGENTS(N)) hs_if ();

  handover_scheduler #(.N_AGENTS(N), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hs    (hs_if)
  );

  typedef struct { logic [N-1:0] grant; int gap; } gexp_t;
  typedef struct { logic done; logic [7:0] cnt; logic [1:0] last; int lat; } eexp_t;

  gexp_t gq[$];
  eexp_t eq[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int send_cyc = 0;
  logic [N-1:0] cur_grant = '0;

  // reference model state
  int m_ptr = 0;
  int m_cnt = 0;
  int prev_lat = 0;
  bit prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  gexp_t mg;
  eexp_t me;
  always @(negedge clk) begin
    if (rst_n) begin
      if (hs_if.send_en) begin
        if (gq.size() == 0) check("send_en_unexpected", 1, 0);
        else begin
          mg = gq.pop_front();
          check("grant", hs_if.grant, mg.grant);
          if (mg.gap > 0) check("turnaround", cyc - send_cyc, mg.gap);
          cur_grant = mg.grant;
        end
        send_cyc = cyc;
      end
      if (hs_if.done || hs_if.timeout_err) begin
        if (eq.size() == 0) check("end_unexpected", 1, 0);
        else begin
          me = eq.pop_front();
          check("done", hs_if.done, me.done);
          check("timeout_err", hs_if.timeout_err, !me.done);
          check("handover_count", hs_if.handover_count, me.cnt);
          check("last_owner", hs_if.last_owner, me.last);
          check("latency", cyc - send_cyc, me.lat);
          check("grant_released", hs_if.grant, 0);
        end
        cur_grant = '0;
      end else if (hs_if.busy) begin
        check("grant_held", hs_if.grant, cur_grant);
      end
    end
  end

  // Predict one handover for request vector r with ack arriving after d WAIT_ACK cycles.
  task automatic model_push(input logic [N-1:0] r, input int d);
    gexp_t g;
    eexp_t e;
    int winner;
    winner = 0;
    for (int k = 0; k < N; k++) begin
      if (r[(m_ptr + k) % N]) begin
        winner = (m_ptr + k) % N;
        break;
      end
    end
    g.grant = '0;
    g.grant[winner] = 1'b1;
    g.gap = prev_valid ? prev_lat + 2 : 0;
    e.done = (d < TO);
    if (e.done) m_cnt = (m_cnt + 1) % 256;
    e.cnt  = 8'(m_cnt);
    e.last = 2'(winner);
    e.lat  = e.done ? d + 2 : TO + 1;
    m_ptr  = (winner + 1) % N;
    prev_lat = e.lat;
    gq.push_back(g);
    eq.push_back(e);
  endtask

  // Issue one handover from a negedge; returns at the negedge of its RELEASE cycle.
  task automatic do_ho(input logic [N-1:0] r, input int d, input int idle);
    bit seen;
    if (idle > 0) begin
      prev_valid = 1'b0;
      hs_if.req = '0;
      repeat (idle) begin
        hs_if.ack = 1'($urandom);
        @(negedge clk);
      end
    end
    hs_if.req = r;
    hs_if.ack = 1'($urandom);
    model_push(r, d);
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clk);
      seen = hs_if.send_en;
    end
    if (!seen) begin
      check("send_en_wait", 0, 1);
      prev_valid = 1'b0;
      return;
    end
    hs_if.ack = 1'($urandom);
    seen = 1'b0;
    for (int w = 0; w < TO + 4 && !seen; w++) begin
      @(negedge clk);
      seen = hs_if.done || hs_if.timeout_err;
      if (!seen) begin
        hs_if.ack = (w >= d);
        if ($urandom_range(0, 3) == 0) hs_if.req = N'($urandom);
      end
    end
    if (!seen) check("end_wait", 0, 1);
    prev_valid = seen;
    hs_if.ack = 1'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, expected summary");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    hs_if.req = '0;
    hs_if.ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", hs_if.grant, 0);
    check("rst_send_en", hs_if.send_en, 0);
    check("rst_busy", hs_if.busy, 0);
    check("rst_done", hs_if.done, 0);
    check("rst_timeout_err", hs_if.timeout_err, 0);
    check("rst_count", hs_if.handover_count, 0);
    check("rst_last_owner", hs_if.last_owner, 0);
    rst_n = 1'b1;

    do_ho(4'b0001, 0, 3);
    repeat (5) do_ho(4'b1111, 0, 0);
    do_ho(4'b0010, TO + 2, 0);
    do_ho(4'b0111, 0, 0);
    do_ho(4'b0001, TO - 1, 0);
    do_ho(4'b1000, TO - 1, 2);

    for (int t = 0; t < 400; t++) begin
      logic [N-1:0] r;
      int d, idle;
      r = N'($urandom_range(1, 15));
      d = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(TO - 2, TO + 1);
      idle = ($urandom_range(0, 5) < 4) ? 0 : $urandom_range(1, 2);
      do_ho(r, d, idle);
    end

    // abort a transaction in WAIT_ACK by reset
    prev_valid = 1'b0;
    hs_if.req = 4'b0001;
    hs_if.ack = 1'b0;
    model_push(4'b0001, TO + 5);
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clk);
      seen = hs_if.send_en;
    end
    if (!seen) check("send_en_wait_rst", 0, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_grant", hs_if.grant, 0);
    check("mid_rst_busy", hs_if.busy, 0);
    check("mid_rst_send_en", hs_if.send_en, 0);
    check("mid_rst_done", hs_if.done, 0);
    check("mid_rst_timeout_err", hs_if.timeout_err, 0);
    check("mid_rst_count", hs_if.handover_count, 0);
    check("mid_rst_last_owner", hs_if.last_owner, 0);
    gq.delete();
    eq.delete();
    cur_grant = '0;
    m_ptr = 0;
    m_cnt = 0;
    prev_valid = 1'b0;
    hs_if.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_ho(4'b0101, 0, 0);
    do_ho(4'b0100, 1, 0);

    repeat (3) @(negedge clk);
    check("queues_drained", gq.size() + eq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
